// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants for the instruction fetch controller: FSM encoding,
// default reset PC and halt word, plus an alignment helper.
package pc_fetch_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_next_mux.sv
// Next-PC selection: jump target over branch target over pc+4.
// PC_ALIGN_CHECK_EN: flag misaligned redirect targets instead of masking them.
module pc_next_mux
  import pc_fetch_ctrl_pkg::*;
(
  input  logic        jmp_sel,
  input  logic [31:0] jmp_target,
  input  logic        br_sel,
  input  logic [31:0] br_target,
  input  logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        target_misalign
);

  logic [31:0] target_s;
  logic        redirect_s;

  // Priority select of the raw redirect target
  always_comb begin
    target_s   = pc_plus4;
    redirect_s = 1'b0;
    if (jmp_sel) begin
      target_s   = jmp_target;
      redirect_s = 1'b1;
    end else if (br_sel) begin
      target_s   = br_target;
      redirect_s = 1'b1;
    end else begin
      target_s   = pc_plus4;
      redirect_s = 1'b0;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Targets pass through untouched; the controller halts on a misaligned one
  always_comb begin
    next_pc         = target_s;
    target_misalign = redirect_s && !is_word_aligned(target_s);
  end
`else
  // pc+4 is always aligned, so masking every target is harmless
  always_comb begin
    next_pc         = target_s & 32'hFFFF_FFFC;
    target_misalign = 1'b0;
  end
`endif

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: issues imem requests at pc, latches redirects
// until the fetch completes, and halts on HALT_WORD. Option: PC_ALIGN_CHECK_EN.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        misalign
);

  logic [1:0]  state_r, state_nxt_s;
  logic [31:0] pc_r, instr_r;
  logic        instr_valid_r, misalign_r;
  logic        pend_jmp_r, pend_br_r;
  logic [31:0] pend_jmp_tgt_r, pend_br_tgt_r;

  logic        active_s, req_s, done_s;
  logic        jmp_sel_s, br_sel_s;
  logic [31:0] jmp_tgt_s, br_tgt_s, pc_plus4_s, next_pc_s;
  logic        tgt_misalign_s;

  assign pc_plus4_s = pc_r + 32'd4;

  // Request/completion decode; a same-cycle redirect overrides the pending one
  always_comb begin
    active_s = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
    if (state_r == ST_WAIT) begin
      req_s = 1'b1;
    end else if (state_r == ST_ISSUE) begin
      req_s = !stall;
    end else begin
      req_s = 1'b0;
    end
    done_s    = req_s && imem_ack;
    jmp_sel_s = active_s && (jmp || pend_jmp_r);
    jmp_tgt_s = jmp ? jmp_target : pend_jmp_tgt_r;
    br_sel_s  = active_s && (br_taken || pend_br_r);
    br_tgt_s  = br_taken ? br_target : pend_br_tgt_r;
  end

  pc_next_mux u_next_mux (
    .jmp_sel         (jmp_sel_s),
    .jmp_target      (jmp_tgt_s),
    .br_sel          (br_sel_s),
    .br_target       (br_tgt_s),
    .pc_plus4        (pc_plus4_s),
    .next_pc         (next_pc_s),
    .target_misalign (tgt_misalign_s)
  );

  // FSM next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_ISSUE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_ISSUE, ST_WAIT: begin
        if (done_s) begin
          if (tgt_misalign_s || (imem_rdata == HALT_WORD)) state_nxt_s = ST_HALT;
          else                                            state_nxt_s = ST_ISSUE;
        end else if (req_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, PC and fetched-word registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      instr_r       <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      misalign_r    <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      instr_valid_r <= done_s;
      misalign_r    <= done_s && tgt_misalign_s;
      if (done_s) begin
        instr_r <= imem_rdata;
        if (!tgt_misalign_s) pc_r <= next_pc_s;
      end
    end
  end

  // Pending redirect latch, one slot per redirect kind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_jmp_r     <= 1'b0;
      pend_br_r      <= 1'b0;
      pend_jmp_tgt_r <= 32'h0000_0000;
      pend_br_tgt_r  <= 32'h0000_0000;
    end else if (done_s) begin
      pend_jmp_r <= 1'b0;
      pend_br_r  <= 1'b0;
    end else if (active_s) begin
      if (jmp) begin
        pend_jmp_r     <= 1'b1;
        pend_jmp_tgt_r <= jmp_target;
      end
      if (br_taken) begin
        pend_br_r     <= 1'b1;
        pend_br_tgt_r <= br_target;
      end
    end
  end

  assign imem_req    = req_s;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_plus4_s;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign halted      = (state_r == ST_HALT);
  assign misalign    = misalign_r;

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameters SHALL be:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, fetched word that stops fetching.

REQ-002 Ports SHALL be as follows. One clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; leave IDLE
- stall  in  1  suppress new fetch issue
- br_taken  in  1  branch redirect request
- br_target  in  32  branch target
- jmp  in  1  jump redirect request
- jmp_target  in  32  jump target
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  fetch address, equal to pc
- imem_ack  in  1  fetch complete; rdata valid this cycle
- imem_rdata  in  32  fetched word
- instr  out  32  last fetched word
- instr_valid  out  1  one-cycle pulse per fetched word
- pc  out  32  current fetch PC
- pc_plus4  out  32  pc + 4, combinational
- halted  out  1  high in HALT
- misalign  out  1  one-cycle misaligned-target pulse

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, WAIT, HALT.
REQ-004 Transitions SHALL be:
- IDLE to ISSUE when start=1.
- ISSUE with stall=1: stay, imem_req=0.
- ISSUE with stall=0: imem_req=1; if imem_ack=1 the fetch completes this cycle, otherwise go to WAIT.
- WAIT: imem_req=1 and imem_addr held stable until imem_ack=1. stall is ignored.
REQ-005 On the completion edge:
- instr<=imem_rdata.
- instr_valid=1 for exactly the next cycle.
- pc<=next_pc.
- Next state is HALT if imem_rdata==HALT_WORD, otherwise ISSUE.
REQ-006 With zero-wait ack, the block SHALL sustain one fetch per cycle.
REQ-007 next_pc priority SHALL be: jmp_target, then br_target, then pc_plus4. jmp wins over a simultaneous br_taken.
REQ-008 A redirect asserted in ISSUE or WAIT before completion SHALL be latched as pending and applied at completion. A later redirect before completion overwrites it under the REQ-007 priority. The pending redirect clears at completion.
REQ-009 A redirect asserted in IDLE or HALT SHALL be ignored.
REQ-010 pc_plus4 SHALL wrap modulo 2^32: pc=32'hFFFF_FFFC gives 32'h0000_0000.
REQ-011 HALT SHALL be exited only by reset. In HALT, imem_req=0 and pc is frozen.
REQ-012 imem_addr SHALL always equal pc.

Reset
REQ-013 While rst_n=0, outputs SHALL be:
- state=IDLE
- pc=RESET_PC
- instr=0, instr_valid=0, imem_req=0, halted=0, misalign=0
- pending redirect cleared
REQ-014 Reset asserted mid-fetch SHALL abandon the fetch without waiting for ack. An ack arriving after reset is released, while in IDLE, SHALL be ignored.

Configuration
REQ-015 With PC_ALIGN_CHECK_EN defined, a selected redirect target with bits[1:0]!=0 at completion SHALL:
- pulse misalign for one cycle,
- leave pc unchanged,
- enter HALT.
REQ-016 Without PC_ALIGN_CHECK_EN, redirect target bits[1:0] SHALL be forced to 2'b00 and misalign tied to 0.

Structure
REQ-017 Package pc_fetch_ctrl_pkg SHALL hold the FSM state encoding and the RESET_PC and HALT_WORD default constants.
REQ-018 Next-PC selection (REQ-007, REQ-015/016 masking) SHALL be a sub-module pc_next_mux. The FSM, PC register and pending-redirect latch stay in pc_fetch_ctrl.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, start, zero-wait ack, words 0x1,0x2 -> pc 0x3000->0x3004->0x3008; instr_valid pulses two consecutive cycles.
- Ack delayed 3 cycles -> imem_req high 4 cycles; imem_addr=0x3000 stable; one instr_valid pulse.
- br_taken (target 0x3100) and jmp (target 0x3200) together in WAIT, then ack -> pc=0x3200.
- stall=1 in ISSUE for 5 cycles -> imem_req=0 and pc unchanged; stall=0 -> request issued same cycle.
- Fetch returns 0xFFFF_FFFF -> halted=1; imem_req stays 0 despite start or jmp; rst_n low mid-WAIT -> pc=0x3000, IDLE.
- With PC_ALIGN_CHECK_EN, jmp_target 0x3202 -> misalign pulse, HALT; without the macro -> pc=0x3200.
